// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Holds the FSM state encoding, the grant IDs used by the round-robin pointer,
// and the default wait limit for an outstanding memory access.
package mem_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Grant IDs; they double as bit positions in the 2-bit request/grant vectors
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Default number of BUSY cycles to wait for mem_ack_in before giving up
  localparam int TIMEOUT_DEFAULT = 255;

  // Size code driven on the memory port for instruction fetches
  localparam logic [1:0] FETCH_SIZE = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester and shared-memory-port signals of mem_arbiter.
// slave  : arbiter view (takes requests and mem_ack_in, drives acks and the memory command).
// master : environment view (requesters plus the memory model).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction-fetch requester
  logic                  i_req_in;
  logic [ADDR_WIDTH-1:0] i_addr_in;
  logic                  i_ack_out;
  logic [DATA_WIDTH-1:0] i_rdata_out;
  // data requester
  logic                  d_req_in;
  logic                  d_we_in;
  logic [1:0]            d_size_in;
  logic [ADDR_WIDTH-1:0] d_addr_in;
  logic [DATA_WIDTH-1:0] d_wdata_in;
  logic                  d_ack_out;
  logic [DATA_WIDTH-1:0] d_rdata_out;
  logic                  err_out;
  // shared memory port
  logic                  mem_req_out;
  logic                  mem_we_out;
  logic [1:0]            mem_size_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic                  mem_ack_in;
  logic [DATA_WIDTH-1:0] mem_rdata_in;

  modport slave (
    input  i_req_in, i_addr_in,
    input  d_req_in, d_we_in, d_size_in, d_addr_in, d_wdata_in,
    input  mem_ack_in, mem_rdata_in,
    output i_ack_out, i_rdata_out, d_ack_out, d_rdata_out, err_out,
    output mem_req_out, mem_we_out, mem_size_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output i_req_in, i_addr_in,
    output d_req_in, d_we_in, d_size_in, d_addr_in, d_wdata_in,
    output mem_ack_in, mem_rdata_in,
    input  i_ack_out, i_rdata_out, d_ack_out, d_rdata_out, err_out,
    input  mem_req_out, mem_we_out, mem_size_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: combinational 2-way round-robin pick.
// Ports: req[1:0] (bit GRANT_I / GRANT_D), last_grant -> one-hot grant[1:0].
// Zero latency; a lone request always wins, a conflict goes to the one not served last.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == GRANT_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction-fetch and data requesters.
// Ports: clock, reset (sync, active-high), bus (mem_arbiter_if.slave: requester and memory signals).
// Latency: grant edge -> mem_req_out next cycle; mem_ack_in -> x_ack_out next cycle; one access at a time,
// other requester simply waits (level request) while BUSY; TIMEOUT wait cycles end the access with err_out.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  // the wait counter hits TIMEOUT on the edge that ends the access
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state;
  logic                  last_grant;
  logic [7:0]            wait_cnt;
  logic [1:0]            req_masked;
  logic [1:0]            grant;

  logic                  i_ack_q;
  logic                  d_ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [1:0]            mem_size_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // A requester being acked this cycle still holds its level request; masking it
  // stops the same access being granted twice and lets the other side in.
  assign req_masked[GRANT_I] = bus.i_req_in & ~i_ack_q;
  assign req_masked[GRANT_D] = bus.d_req_in & ~d_ack_q;

  arb_rr2 u_rr2 (
    .req        (req_masked),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_D;
      wait_cnt    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // ack pulses and read data last exactly one cycle
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;

      case (state)
        ST_IDLE: begin
          // mem_ack_in is deliberately not looked at here
          if (grant[GRANT_I]) begin
            state       <= ST_BUSY_I;
            last_grant  <= GRANT_I;
            wait_cnt    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_size_q  <= FETCH_SIZE;
            mem_addr_q  <= bus.i_addr_in;
            mem_wdata_q <= '0;
          end else if (grant[GRANT_D]) begin
            state       <= ST_BUSY_D;
            last_grant  <= GRANT_D;
            wait_cnt    <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we_in;
            mem_size_q  <= bus.d_size_in;
            mem_addr_q  <= bus.d_addr_in;
            mem_wdata_q <= bus.d_wdata_in;
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          // command registers are left untouched so the port stays stable
          if (bus.mem_ack_in) begin
            state     <= ST_IDLE;
            mem_req_q <= 1'b0;
            if (state == ST_BUSY_I) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.mem_rdata_in;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= bus.mem_rdata_in;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // give up: error ack with zero data
            state     <= ST_IDLE;
            mem_req_q <= 1'b0;
            wait_cnt  <= wait_cnt + 8'd1;
            err_q     <= 1'b1;
            if (state == ST_BUSY_I) begin
              i_ack_q <= 1'b1;
            end else begin
              d_ack_q <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ack_out     = i_ack_q;
  assign bus.i_rdata_out   = i_rdata_q;
  assign bus.d_ack_out     = d_ack_q;
  assign bus.d_rdata_out   = d_rdata_q;
  assign bus.err_out       = err_q;
  assign bus.mem_req_out   = mem_req_q;
  assign bus.mem_we_out    = mem_we_q;
  assign bus.mem_size_out  = mem_size_q;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_wdata_out = mem_wdata_q;

endmodule
